wave_counter_fsm: RTL

Parametrised successor to the sawtooth counter FSM. It loads bounds N1/N2 from a data bus using the select button and runs on start. Between the bounds it generates a rising sawtooth, a falling sawtooth or a triangle waveform, with programmable step, pause/resume and bound-error detection. It sits after the input synchronisers and is paced by a one-cycle tick enable from the clock divider instead of a divided clock. It feeds the BCD/seven-segment display path, the LEDs and the debug indicator.

---
 rtl/wave_counter_fsm.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/wave_counter_fsm.sv
// Bound-loading waveform generator: loads N1/N2 via select, then produces saw-up,
// saw-down or triangle between them on each tick; registered outputs, no backpressure.
module wave_counter_fsm #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic              v_i,
    input  logic              st_i,
    input  logic [WIDTH-1:0]  din_i,
    input  logic [1:0]        mode_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [WIDTH-1:0]  dind_o,
    output logic [WIDTH-1:0]  n1_o,
    output logic [WIDTH-1:0]  n2_o,
    output logic [WIDTH-1:0]  cnt_o,
    output logic [2:0]        state_o,
    output logic              run_o,
    output logic              wrap_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_N1 = 3'd1,
        S_LOAD_N2 = 3'd2,
        S_READY   = 3'd3,
        S_RUN     = 3'd4,
        S_PAUSE   = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_cnt, r_n1, r_n2, r_dind;
    logic [WIDTH-1:0] w_cnt_nx, w_n1_nx, w_n2_nx, w_dind_nx;
    logic             r_dir_dn, w_dir_dn_nx;
    logic             r_v_d, r_st_d, r_wrap, r_run, r_err, w_wrap_nx;
    logic             w_v_rise, w_st_rise;
    logic [WIDTH:0]   w_s, w_cnt_x, w_up, w_dn, w_n1s, w_n1_x, w_n2_x;

    assign w_v_rise  = v_i & ~r_v_d;
    assign w_st_rise = st_i & ~r_st_d;

    // One extra bit of headroom so cnt+s and n1+s never wrap around.
    assign w_s     = (step_i == '0) ? (WIDTH+1)'(1) : (WIDTH+1)'(step_i);
    assign w_cnt_x = {1'b0, r_cnt};
    assign w_n1_x  = {1'b0, r_n1};
    assign w_n2_x  = {1'b0, r_n2};
    assign w_up    = w_cnt_x + w_s;
    assign w_dn    = w_cnt_x - w_s;
    assign w_n1s   = w_n1_x + w_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_n1     <= '0;
            r_n2     <= '0;
            r_dind   <= '0;
            r_dir_dn <= 1'b0;
            r_v_d    <= 1'b0;
            r_st_d   <= 1'b0;
            r_wrap   <= 1'b0;
            r_run    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_n1     <= w_n1_nx;
            r_n2     <= w_n2_nx;
            r_dind   <= w_dind_nx;
            r_dir_dn <= w_dir_dn_nx;
            r_v_d    <= v_i;
            r_st_d   <= st_i;
            r_wrap   <= w_wrap_nx;
            r_run    <= (w_state_nx == S_RUN);
            r_err    <= (w_state_nx == S_ERR);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_n1_nx     = r_n1;
        w_n2_nx     = r_n2;
        w_dir_dn_nx = r_dir_dn;
        w_wrap_nx   = 1'b0;
        case (r_state)
            S_IDLE: if (w_v_rise) w_state_nx = S_LOAD_N1;
            S_LOAD_N1: if (w_v_rise) begin
                w_n1_nx    = din_i;
                w_state_nx = S_LOAD_N2;
            end
            S_LOAD_N2: if (w_v_rise) begin
                w_n2_nx    = din_i;
                w_state_nx = S_READY;
            end
            S_READY: begin
                if (w_v_rise) begin
                    w_state_nx = S_LOAD_N1;
                end else if (w_st_rise) begin
                    if (r_n1 <= r_n2) begin
                        w_state_nx  = S_RUN;
                        w_cnt_nx    = (mode_i == 2'b01) ? r_n2 : r_n1;
                        w_dir_dn_nx = 1'b0;
                    end else begin
                        w_state_nx = S_ERR;
                    end
                end
            end
            S_RUN: begin
                if (w_st_rise) begin
                    w_state_nx = S_PAUSE;
                end else if (tick_i) begin
                    // Degenerate range: triangle would otherwise turn without wrapping.
                    if (r_n1 == r_n2) begin
                        w_cnt_nx  = r_n1;
                        w_wrap_nx = 1'b1;
                    end else if (mode_i == 2'b01) begin
                        if (w_cnt_x < w_n1s) begin
                            w_cnt_nx  = r_n2;
                            w_wrap_nx = 1'b1;
                        end else begin
                            w_cnt_nx = w_dn[WIDTH-1:0];
                        end
                    end else if (mode_i == 2'b10) begin
                        if (!r_dir_dn) begin
                            if (w_up >= w_n2_x) begin
                                w_cnt_nx    = r_n2;
                                w_dir_dn_nx = 1'b1;
                            end else begin
                                w_cnt_nx = w_up[WIDTH-1:0];
                            end
                        end else if (w_cnt_x <= w_n1s) begin
                            w_cnt_nx    = r_n1;
                            w_dir_dn_nx = 1'b0;
                            w_wrap_nx   = 1'b1;
                        end else begin
                            w_cnt_nx = w_dn[WIDTH-1:0];
                        end
                    end else begin
                        if (w_up > w_n2_x) begin
                            w_cnt_nx  = r_n1;
                            w_wrap_nx = 1'b1;
                        end else begin
                            w_cnt_nx = w_up[WIDTH-1:0];
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (w_v_rise)       w_state_nx = S_LOAD_N1;
                else if (w_st_rise) w_state_nx = S_RUN;
            end
            S_ERR: if (w_v_rise) w_state_nx = S_LOAD_N1;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_dind_nx = '0;
        case (w_state_nx)
            S_LOAD_N1, S_LOAD_N2: w_dind_nx = din_i;
            S_READY:              w_dind_nx = w_n2_nx;
            S_RUN, S_PAUSE:       w_dind_nx = w_cnt_nx;
            S_ERR:                w_dind_nx = w_n1_nx;
            default:              w_dind_nx = '0;
        endcase
    end

    assign dind_o  = r_dind;
    assign n1_o    = r_n1;
    assign n2_o    = r_n2;
    assign cnt_o   = r_cnt;
    assign state_o = r_state;
    assign run_o   = r_run;
    assign wrap_o  = r_wrap;
    assign err_o   = r_err;

endmodule
